step_phase_monitor: RTL and testbench
=====================================

STEP_PHASE_MONITOR -- requirements
Module: step_phase_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: cycles a synchronized coil pattern must hold unchanged before it is accepted (range 1..255).
REQ-002 Parameter MOVE_TIMEOUT, default 1048576: cycles without an accepted step before moving deasserts (range 2..2^24-1).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A1, B1, A2, B2  input  1 each  coil drive levels from the stepper pins; asynchronous to clk.
REQ-006 clear  input  1  synchronous: zero position and error state.
REQ-007 position  output  14  signed net step count.
REQ-008 dir  output  1  direction of last counted step (1 = forward, 0 = backward).
REQ-009 step_pulse  output  1  one-cycle strobe per counted step.
REQ-010 moving  output  1  a step was counted within the last MOVE_TIMEOUT cycles.
REQ-011 phase  output  3  accepted pattern code: 0 idle, 1..4 = P1..P4, 7 invalid.
REQ-012 err  output  1  sticky illegal-transition flag.
REQ-013 err_count  output  8  illegal transitions seen, saturating at 255.

Function
REQ-014 The block SHALL pass each coil input through a 2-flop synchronizer; all decoding uses the synchronized 4-bit pattern {A1,B1,A2,B2}.
REQ-015 Decode SHALL be: 0000 idle, 1100 P1, 0110 P2, 0011 P3, 1001 P4, any other value invalid.
REQ-016 Deglitch: a stability counter SHALL reset on every change of the synchronized pattern; the pattern becomes accepted when it has been held STABLE_CYCLES consecutive cycles.
REQ-017 The block SHALL hold the last accepted pattern; phase reflects it, updating on the acceptance cycle.
REQ-018 The block SHALL keep a last_valid phase register (P1..P4 or none); idle and invalid patterns do not overwrite it.
REQ-019 On acceptance of Pn with last_valid = none, the block SHALL set last_valid = Pn and count no step.
REQ-020 On acceptance of Pn equal to last_valid, e.g. a return from idle to the same phase, the block SHALL count nothing.
REQ-021 Forward order SHALL be P1->P2->P3->P4->P1; an accepted successor of last_valid counts +1, sets dir=1, and updates last_valid.
REQ-022 An accepted predecessor of last_valid SHALL count -1, set dir=0, and update last_valid.
REQ-023 An accepted phase two positions away (P1<->P3, P2<->P4) SHALL count nothing, set err, increment err_count, and set last_valid = the new phase.
REQ-024 Acceptance of an invalid pattern SHALL set err, increment err_count, set phase=7, and set last_valid = none.
REQ-025 Acceptance of idle SHALL set phase=0 and leave last_valid and position unchanged.
REQ-026 position SHALL wrap modulo 2^14 in two's complement (+8191 +1 -> -8192; -8192 -1 -> +8191).
REQ-027 Latency: step_pulse, position and dir SHALL update 1 cycle after the acceptance cycle, which is 2 + STABLE_CYCLES cycles after the raw pin edge.
REQ-028 The move timer SHALL reload to MOVE_TIMEOUT on each counted step and decrement otherwise; moving = (timer != 0).
REQ-029 clear SHALL zero position, err and err_count on the next edge, leaving last_valid, phase, dir and moving intact.
REQ-030 If clear coincides with a counted step, the step SHALL be discarded (position = 0) but step_pulse, dir and the move timer still update.
REQ-031 err_count SHALL saturate at 255; err stays 1 until clear or reset.

Reset
REQ-032 reset SHALL dominate clear and all other inputs.
REQ-033 On reset, position=0, dir=0, step_pulse=0, moving=0, phase=0, err=0, err_count=0, last_valid=none, synchronizers=0, stability counter=0, move timer=0.
REQ-034 Reset asserted mid-step SHALL abandon the pending acceptance; after release the next accepted phase is treated as a first phase (REQ-019).

Verification
REQ-035 Forward: from reset, drive P1,P2,P3,P4,P1, each held 10 cycles -> position=4, dir=1, exactly 4 step_pulses, err=0.
REQ-036 Reverse and idle: drive P1,P4,P3, then 0000, then P3,P2 -> position=-3, dir=0, phase=0 during idle, no step on the idle->P3 re-entry.
REQ-037 Glitch: at STABLE_CYCLES=4, hold P1, pulse P2 for 3 cycles, return to P1 -> no step_pulse, position unchanged.
REQ-038 Illegal: drive P1 then P3 -> err=1, err_count=1, position unchanged; then P4 -> position=+1.
REQ-039 Wrap and clear: preload to +8191 via steps, one forward step -> -8192; assert clear on a step cycle -> position=0, step_pulse=1.
REQ-040 Timeout: at MOVE_TIMEOUT=16, one step then quiet -> moving=1 for 16 cycles then 0; reset mid-sequence -> all outputs per REQ-033.

Source files
------------

// File: rtl/step_phase_monitor.sv
// Stepper coil phase monitor.
// Synchronizes the four coil drive pins, deglitches the combined pattern,
// decodes it into one of four full-step phases, and tracks the net step
// count, direction, motion activity and illegal phase transitions.
module step_phase_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int MOVE_TIMEOUT  = 1048576
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               A1,
    input  logic               B1,
    input  logic               A2,
    input  logic               B2,
    input  logic               clear,
    output logic signed [13:0] position,
    output logic               dir,
    output logic               step_pulse,
    output logic               moving,
    output logic [2:0]         phase,
    output logic               err,
    output logic [7:0]         err_count
);

    localparam logic [7:0]  STABLE  = 8'(STABLE_CYCLES);
    localparam logic [23:0] TIMEOUT = 24'(MOVE_TIMEOUT);

    // Encodings line up with the phase codes so P1..P4 compare directly.
    typedef enum logic [2:0] {
        LV_NONE = 3'd0,
        LV_P1   = 3'd1,
        LV_P2   = 3'd2,
        LV_P3   = 3'd3,
        LV_P4   = 3'd4
    } last_valid_t;

    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  prev_pattern;
    logic [7:0]  stable_count;
    logic [7:0]  held_next;
    logic        accept;
    logic [2:0]  code;
    logic        acc_pend;
    logic [2:0]  acc_code;
    last_valid_t state;
    last_valid_t state_next;
    logic [2:0]  succ_code;
    logic [2:0]  pred_code;
    logic        count_up;
    logic        count_down;
    logic        illegal;
    logic [23:0] move_timer;

    // Two-flop synchronizer for the asynchronous coil pins, packed as {A1,B1,A2,B2}.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= {A1, B1, A2, B2};
            sync2 <= sync1;
        end
    end

    // Run length of the current synchronized pattern (saturating at the threshold);
    // acceptance fires exactly once, in the cycle the run reaches the threshold.
    always_comb begin
        held_next = 8'd1;
        if (sync2 == prev_pattern) begin
            held_next = (stable_count == STABLE) ? STABLE : stable_count + 8'd1;
        end
        accept = (held_next == STABLE) &&
                 !((sync2 == prev_pattern) && (stable_count == STABLE));
    end

    // Stability counter and previous-pattern register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pattern <= 4'b0000;
            stable_count <= 8'd0;
        end else begin
            prev_pattern <= sync2;
            stable_count <= held_next;
        end
    end

    // Pattern decode: idle, the four full-step phases, or invalid.
    always_comb begin
        case (sync2)
            4'b0000: code = 3'd0;
            4'b1100: code = 3'd1;
            4'b0110: code = 3'd2;
            4'b0011: code = 3'd3;
            4'b1001: code = 3'd4;
            default: code = 3'd7;
        endcase
    end

    // Accepted phase output plus a one-cycle pending event for the step logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_pend <= 1'b0;
            acc_code <= 3'd0;
            phase    <= 3'd0;
        end else begin
            acc_pend <= accept;
            if (accept) begin
                acc_code <= code;
                phase    <= code;
            end
        end
    end

    // Last-valid-phase state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LV_NONE;
        end else begin
            state <= state_next;
        end
    end

    // Next last-valid phase: any accepted phase replaces it, invalid clears it, idle keeps it.
    always_comb begin
        state_next = state;
        if (acc_pend) begin
            case (acc_code)
                3'd0:    state_next = state;
                3'd1:    state_next = LV_P1;
                3'd2:    state_next = LV_P2;
                3'd3:    state_next = LV_P3;
                3'd4:    state_next = LV_P4;
                default: state_next = LV_NONE;
            endcase
        end
    end

    // Classify the pending acceptance against the last valid phase.
    always_comb begin
        count_up   = 1'b0;
        count_down = 1'b0;
        illegal    = 1'b0;
        succ_code  = 3'd0;
        pred_code  = 3'd0;
        case (state)
            LV_P1:   begin succ_code = 3'd2; pred_code = 3'd4; end
            LV_P2:   begin succ_code = 3'd3; pred_code = 3'd1; end
            LV_P3:   begin succ_code = 3'd4; pred_code = 3'd2; end
            LV_P4:   begin succ_code = 3'd1; pred_code = 3'd3; end
            default: begin succ_code = 3'd0; pred_code = 3'd0; end
        endcase
        if (acc_pend) begin
            if (acc_code == 3'd7) begin
                illegal = 1'b1;
            end else if ((acc_code != 3'd0) && (state != LV_NONE) &&
                         (acc_code != 3'(state))) begin
                if (acc_code == succ_code) begin
                    count_up = 1'b1;
                end else if (acc_code == pred_code) begin
                    count_down = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
        end
    end

    // Step strobe, direction and move timer; clear does not affect these.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_pulse <= 1'b0;
            dir        <= 1'b0;
            move_timer <= 24'd0;
        end else begin
            step_pulse <= count_up | count_down;
            if (count_up) begin
                dir <= 1'b1;
            end else if (count_down) begin
                dir <= 1'b0;
            end
            if (count_up | count_down) begin
                move_timer <= TIMEOUT;
            end else if (move_timer != 24'd0) begin
                move_timer <= move_timer - 24'd1;
            end
        end
    end

    assign moving = (move_timer != 24'd0);

    // Position and error bookkeeping; clear wins over a coincident step or error.
    always_ff @(posedge clk) begin
        if (reset) begin
            position  <= 14'sd0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (clear) begin
            position  <= 14'sd0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (count_up) begin
                position <= position + 14'sd1;
            end else if (count_down) begin
                position <= position - 14'sd1;
            end
            if (illegal) begin
                err <= 1'b1;
                if (err_count != 8'd255) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_phase_monitor.sv
// Self-checking bench for step_phase_monitor: directed scenarios plus a
// randomized pattern sequence checked against a phase-rule reference model.
module tb_step_phase_monitor;

    localparam int S  = 4;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               A1, B1, A2, B2;
    logic               clear;
    logic signed [13:0] position;
    logic               dir;
    logic               step_pulse;
    logic               moving;
    logic [2:0]         phase;
    logic               err;
    logic [7:0]         err_count;

    int err_cnt     = 0;
    int chk_cnt     = 0;
    int pulse_count = 0;

    int   m_pos, m_lv, m_errc, m_phase;
    logic m_err, m_dir;

    step_phase_monitor #(.STABLE_CYCLES(S), .MOVE_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .A1         (A1),
        .B1         (B1),
        .A2         (A2),
        .B2         (B2),
        .clear      (clear),
        .position   (position),
        .dir        (dir),
        .step_pulse (step_pulse),
        .moving     (moving),
        .phase      (phase),
        .err        (err),
        .err_count  (err_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Tally step strobes; sampled at the edge so the value seen is the one held during the prior cycle.
    always @(posedge clk) begin
        if (step_pulse === 1'b1) pulse_count++;
    end

    // Guard against a hung run.
    initial begin
        repeat (200000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle budget exhausted, got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [3:0] pat_of(input int n);
        case (n)
            1:       return 4'b1100;
            2:       return 4'b0110;
            3:       return 4'b0011;
            4:       return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int wrap14(input int v);
        int r;
        r = ((v % 16384) + 16384) % 16384;
        if (r >= 8192) r = r - 16384;
        return r;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_lv = 0; m_errc = 0; m_phase = 0; m_err = 1'b0; m_dir = 1'b0;
    endtask

    // Reference behaviour of one accepted pattern, expressed as modular phase distance.
    task automatic model_accept(input logic [3:0] p);
        int c;
        int d;
        case (p)
            4'b0000: c = 0;
            4'b1100: c = 1;
            4'b0110: c = 2;
            4'b0011: c = 3;
            4'b1001: c = 4;
            default: c = 7;
        endcase
        m_phase = c;
        if (c == 7) begin
            m_err = 1'b1; m_errc = (m_errc < 255) ? m_errc + 1 : 255; m_lv = 0;
        end else if (c != 0) begin
            if (m_lv == 0) begin
                m_lv = c;
            end else begin
                d = (c - m_lv + 4) % 4;
                if (d == 1) begin
                    m_pos = wrap14(m_pos + 1); m_dir = 1'b1;
                end else if (d == 3) begin
                    m_pos = wrap14(m_pos - 1); m_dir = 1'b0;
                end else if (d == 2) begin
                    m_err = 1'b1; m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                end
                m_lv = c;
            end
        end
    endtask

    task automatic drive_pat(input logic [3:0] p, input int n);
        {A1, B1, A2, B2} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clear = 1'b0; {A1, B1, A2, B2} = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b1; {A1, B1, A2, B2} = 4'b1100;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({position, dir, step_pulse, moving, phase, err, err_count} !== 29'd0) begin
            err_cnt++;
            $display("[TB] FAIL reset_outputs: got %h want 0",
                     {position, dir, step_pulse, moving, phase, err, err_count});
        end
        reset = 1'b0; clear = 1'b0; {A1, B1, A2, B2} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int ph_at = 0;
        int pl_at = 0;
        do_reset();
        drive_pat(pat_of(1), 10);
        {A1, B1, A2, B2} = pat_of(2);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (phase === 3'd2 && ph_at == 0) ph_at = i;
            if (step_pulse === 1'b1 && pl_at == 0) pl_at = i;
        end
        chk_cnt++;
        if (ph_at != S + 2) begin
            err_cnt++; $display("[TB] FAIL latency_phase: got %0d want %0d", ph_at, S + 2);
        end
        chk_cnt++;
        if (pl_at != S + 3) begin
            err_cnt++; $display("[TB] FAIL latency_pulse: got %0d want %0d", pl_at, S + 3);
        end
    endtask

    task automatic test_forward();
        int base;
        do_reset();
        base = pulse_count;
        drive_pat(pat_of(1), 10);
        drive_pat(pat_of(2), 10);
        drive_pat(pat_of(3), 10);
        drive_pat(pat_of(4), 10);
        drive_pat(pat_of(1), 10);
        chk_cnt++;
        if (position !== 14'sd4) begin
            err_cnt++; $display("[TB] FAIL fwd_position: got %0d want 4", position);
        end
        chk_cnt++;
        if (dir !== 1'b1 || err !== 1'b0) begin
            err_cnt++; $display("[TB] FAIL fwd_dir_err: got dir=%b err=%b want 1 0", dir, err);
        end
        chk_cnt++;
        if (pulse_count - base != 4) begin
            err_cnt++; $display("[TB] FAIL fwd_pulses: got %0d want 4", pulse_count - base);
        end
    endtask

    task automatic test_reverse_idle();
        int base;
        do_reset();
        base = pulse_count;
        drive_pat(pat_of(1), 10);
        drive_pat(pat_of(4), 10);
        drive_pat(pat_of(3), 10);
        drive_pat(4'b0000, 10);
        chk_cnt++;
        if (phase !== 3'd0 || position !== -14'sd2) begin
            err_cnt++; $display("[TB] FAIL rev_idle: got phase=%0d pos=%0d want 0 -2", phase, position);
        end
        drive_pat(pat_of(3), 10);
        chk_cnt++;
        if (pulse_count - base != 2 || position !== -14'sd2) begin
            err_cnt++;
            $display("[TB] FAIL rev_reentry: got pulses=%0d pos=%0d want 2 -2", pulse_count - base, position);
        end
        drive_pat(pat_of(2), 10);
        chk_cnt++;
        if (position !== -14'sd3 || dir !== 1'b0) begin
            err_cnt++; $display("[TB] FAIL rev_final: got pos=%0d dir=%b want -3 0", position, dir);
        end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        drive_pat(pat_of(1), 10);
        base = pulse_count;
        drive_pat(pat_of(2), S - 1);
        drive_pat(pat_of(1), 10);
        chk_cnt++;
        if (pulse_count != base || position !== 14'sd0 || phase !== 3'd1) begin
            err_cnt++;
            $display("[TB] FAIL glitch: got pulses=%0d pos=%0d phase=%0d want 0 0 1",
                     pulse_count - base, position, phase);
        end
    endtask

    task automatic test_illegal_clear();
        int base;
        do_reset();
        drive_pat(pat_of(1), 10);
        drive_pat(pat_of(3), 10);
        chk_cnt++;
        if (err !== 1'b1 || err_count !== 8'd1 || position !== 14'sd0) begin
            err_cnt++;
            $display("[TB] FAIL illegal_skip: got err=%b cnt=%0d pos=%0d want 1 1 0", err, err_count, position);
        end
        drive_pat(pat_of(4), 10);
        chk_cnt++;
        if (position !== 14'sd1) begin
            err_cnt++; $display("[TB] FAIL illegal_resume: got %0d want 1", position);
        end
        drive_pat(4'b1111, 10);
        chk_cnt++;
        if (phase !== 3'd7 || err_count !== 8'd2) begin
            err_cnt++; $display("[TB] FAIL invalid_pattern: got phase=%0d cnt=%0d want 7 2", phase, err_count);
        end
        base = pulse_count;
        drive_pat(pat_of(2), 10);
        chk_cnt++;
        if (pulse_count != base || position !== 14'sd1) begin
            err_cnt++; $display("[TB] FAIL after_invalid: got pos=%0d want 1 and no step", position);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_cnt++;
        if (position !== 14'sd0 || err !== 1'b0 || err_count !== 8'd0 || phase !== 3'd2) begin
            err_cnt++;
            $display("[TB] FAIL clear: got pos=%0d err=%b cnt=%0d phase=%0d want 0 0 0 2",
                     position, err, err_count, phase);
        end
        drive_pat(pat_of(3), 10);
        chk_cnt++;
        if (position !== 14'sd1) begin
            err_cnt++; $display("[TB] FAIL clear_keeps_last: got %0d want 1", position);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive_pat(pat_of(1), 10);
        for (int i = 0; i < 256; i++) begin
            drive_pat((i % 2 == 0) ? pat_of(3) : pat_of(1), S);
        end
        repeat (6) @(negedge clk);
        chk_cnt++;
        if (err_count !== 8'd255 || err !== 1'b1 || position !== 14'sd0) begin
            err_cnt++;
            $display("[TB] FAIL saturate: got cnt=%0d err=%b pos=%0d want 255 1 0", err_count, err, position);
        end
    endtask

    task automatic test_random();
        logic [3:0] p;
        logic [3:0] prev_p;
        int base;
        int idx;
        int n;
        bit short_run;
        do_reset();
        base   = pulse_count;
        prev_p = 4'b0000;
        for (int it = 0; it < 80; it++) begin
            do begin
                idx = $urandom_range(0, 6);
                p   = (idx <= 4) ? pat_of(idx) : 4'($urandom_range(0, 15));
            end while (p == prev_p);
            short_run = ($urandom_range(0, 2) == 0);
            n = short_run ? $urandom_range(1, S - 1) : $urandom_range(S + 3, S + 8);
            drive_pat(p, n);
            prev_p = p;
            if (!short_run) begin
                model_accept(p);
                chk_cnt++;
                if (position !== 14'(m_pos) || phase !== 3'(m_phase) || err_count !== 8'(m_errc)) begin
                    err_cnt++;
                    $display("[TB] FAIL random_%0d: got pos=%0d phase=%0d cnt=%0d want %0d %0d %0d",
                             it, position, phase, err_count, m_pos, m_phase, m_errc);
                end
                chk_cnt++;
                if (err !== m_err || (m_pos != 0 && dir !== m_dir)) begin
                    err_cnt++;
                    $display("[TB] FAIL random_flags_%0d: got err=%b dir=%b want %b %b",
                             it, err, dir, m_err, m_dir);
                end
            end
        end
    endtask

    task automatic test_wrap_clear();
        int base;
        do_reset();
        drive_pat(pat_of(1), 10);
        base = pulse_count;
        for (int k = 1; k <= 8191; k++) begin
            drive_pat(pat_of((k % 4) + 1), S);
        end
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (position !== 14'sd8191) begin
            err_cnt++; $display("[TB] FAIL preload: got %0d want 8191", position);
        end
        drive_pat(pat_of(1), 10);
        chk_cnt++;
        if (position !== -14'sd8192 || dir !== 1'b1) begin
            err_cnt++; $display("[TB] FAIL wrap: got pos=%0d dir=%b want -8192 1", position, dir);
        end
        chk_cnt++;
        if (pulse_count - base != 8192) begin
            err_cnt++; $display("[TB] FAIL wrap_pulses: got %0d want 8192", pulse_count - base);
        end
        {A1, B1, A2, B2} = pat_of(2);
        repeat (S + 2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_cnt++;
        if (position !== 14'sd0 || step_pulse !== 1'b1 || dir !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL clear_on_step: got pos=%0d pulse=%b dir=%b want 0 1 1", position, step_pulse, dir);
        end
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (position !== 14'sd0 || moving !== 1'b1) begin
            err_cnt++; $display("[TB] FAIL clear_step_timer: got pos=%0d moving=%b want 0 1", position, moving);
        end
    endtask

    task automatic test_timeout_reset();
        int mv_count = 0;
        int mv_first = 0;
        int base;
        do_reset();
        drive_pat(pat_of(1), 10);
        {A1, B1, A2, B2} = pat_of(2);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (moving === 1'b1) begin
                mv_count++;
                if (mv_first == 0) mv_first = i;
            end
        end
        chk_cnt++;
        if (mv_count != TO || mv_first != S + 3) begin
            err_cnt++;
            $display("[TB] FAIL timeout: got cycles=%0d first=%0d want %0d %0d", mv_count, mv_first, TO, S + 3);
        end
        drive_pat(pat_of(3), 10);
        {A1, B1, A2, B2} = pat_of(4);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({position, dir, step_pulse, moving, phase, err, err_count} !== 29'd0) begin
            err_cnt++;
            $display("[TB] FAIL midstep_reset: got %h want 0",
                     {position, dir, step_pulse, moving, phase, err, err_count});
        end
        reset = 1'b0;
        base = pulse_count;
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (pulse_count != base || position !== 14'sd0 || phase !== 3'd4) begin
            err_cnt++;
            $display("[TB] FAIL first_after_reset: got pos=%0d phase=%0d want 0 4 and no step", position, phase);
        end
        drive_pat(pat_of(1), 10);
        chk_cnt++;
        if (position !== 14'sd1 || dir !== 1'b1) begin
            err_cnt++; $display("[TB] FAIL step_after_reset: got pos=%0d dir=%b want 1 1", position, dir);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset = 1'b1; clear = 1'b0; {A1, B1, A2, B2} = 4'b0000;
        model_reset();
        test_reset();
        test_latency();
        test_forward();
        test_reverse_idle();
        test_glitch();
        test_illegal_clear();
        test_saturate();
        test_random();
        test_timeout_reset();
        test_wrap_clear();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
